ysyx_22050133_div_unit: RTL
===========================

// Module: ysyx_22050133_div_unit
// PURPOSE
//  Iterative radix-2 restoring integer divider; the responder end of the EXU div handshake.
//  Executes RV64M DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW.
//  Takes operands on div_valid and returns quotient/remainder with a one-cycle div_ready pulse.
//  The EXU uses div_ready directly as its result-valid.
// PARAMETERS
//  XLEN  64  datapath width; only 64 is supported
// PORTS
//  clk         in   1     clock; one clock domain, rising edge
//  rst         in   1     synchronous reset, active-high
//  flush       in   1     abort the current operation
//  div_valid   in   1     request valid; held high by the initiator until div_ready
//  divw        in   1     1 = 32-bit op (*W); uses bits [31:0] only
//  div_signed  in   1     1 = signed (DIV/REM), 0 = unsigned
//  dividend    in   XLEN  dividend
//  divisor     in   XLEN  divisor
//  div_ready   out  1     one-cycle pulse: quotient/remainder valid this cycle
//  out_valid   out  1     identical to div_ready (kept for interface symmetry)
//  quotient    out  XLEN  registered quotient
//  remainder   out  XLEN  registered remainder
// BEHAVIOUR
//  Reset/flush:
//   - rst: state=IDLE; div_ready=out_valid=0; quotient=remainder=0; counter=0.
//   - rst mid-operation has the same effect; no pulse is emitted.
//  FSM:
//   - IDLE -> BUSY on div_valid.
//   - IDLE -> DONE on div_valid when the op is special (see below).
//   - BUSY -> DONE when the counter hits the last iteration.
//   - DONE -> IDLE always.
//   - flush=1 in any state -> IDLE next cycle, no div_ready. flush beats div_valid.
//  Accept (IDLE && div_valid):
//   - Latch operands.
//   - Operand prep:
//     - divw=1: take [31:0]; sign-extend if div_signed, else zero-extend.
//     - signed: divide |a| by |b|; record neg_q = sa^sb and neg_r = sa.
//   - Load iteration count N = 64 (divw=0) or 32 (divw=1).
//  BUSY:
//   - One quotient bit per cycle, MSB first.
//   - Step: rem = {rem,a_msb}; if rem >= b then rem -= b and q bit = 1.
//   - The partial remainder is 65 bits wide, so no overflow occurs.
//  DONE:
//   - Apply sign fix: q = neg_q ? -q : q; r = neg_r ? -r : r.
//   - divw=1: sign-extend bit 31 of both results, for both signed and unsigned.
//   - Register the results and assert div_ready=out_valid=1 for exactly this cycle.
//  Latency:
//   - Normal op: div_ready is asserted N+1 cycles after the accept edge (65 for 64-bit, 33 for W).
//   - Special op: div_ready is asserted 1 cycle after accept.
//  Special cases (fast path, no iteration):
//   - Divisor == 0: q = all-ones (W: 0xFFFFFFFF sign-extended), r = dividend (W: SEXT of [31:0]).
//   - Signed overflow (MIN / -1, at the op width): q = MIN (sign-extended), r = 0.
//  div_valid is ignored in BUSY/DONE; operands are frozen at accept.
//  If div_valid is still high in the IDLE cycle after DONE, a new op is accepted.
//   - A stalled initiator therefore recomputes and gets an identical result.
//  quotient/remainder hold their last value until the next DONE.
// STRUCTURE
//  Shared package constants:
//   - FSM state encoding (IDLE/BUSY/DONE).
//   - XLEN.
//   - Iteration counts 64/32.
//  Sub-module ysyx_22050133_div_step:
//   - Combinational single restoring iteration: {rem_in,a_bit,b} -> {rem_out,q_bit}.
//   - Instantiated once.
// TESTING
//  1. Unsigned 64-bit: 100 / 7, divw=0, signed=0
//     -> q=14, r=2; div_ready exactly 65 cycles after accept, 1 cycle wide.
//  2. Signed W op: dividend=0xFFFFFFF9 (-7), divisor=2, divw=1, signed=1
//     -> q=0xFFFFFFFFFFFFFFFD, r=0xFFFFFFFFFFFFFFFF; ready after 33 cycles.
//  3. Divide by zero: 0x1234 / 0, signed=1, divw=0
//     -> q=0xFFFFFFFFFFFFFFFF, r=0x1234; ready 1 cycle after accept.
//  4. Overflow: 0x8000000000000000 / -1, signed
//     -> q=0x8000000000000000, r=0.
//     W variant 0x80000000 / 0xFFFFFFFF -> q=0xFFFFFFFF80000000, r=0.
//  5. Flush: start 100/7, flush at BUSY cycle 10
//     -> no div_ready; IDLE next cycle; a following 9/4 gives q=2, r=1.
//  6. Back-to-back: hold div_valid with new operands (DIVUW 0xFFFFFFFF / 2) in the cycle after div_ready
//     -> accepted immediately; q=0x000000007FFFFFFF, r=1.
//     Mid-op rst -> all outputs 0, no pulse.

Source files
------------

// File: rtl/ysyx_22050133_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050133_div_unit_pkg
// Description : Shared constants and types for the iterative integer divider
//               (datapath width, iteration counts, FSM state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22050133_div_unit_pkg;

   localparam int XLEN  = 64;
   localparam int CNT_W = 7;

   // One quotient bit per iteration: full-width ops and *W ops
   localparam logic [CNT_W-1:0] ITER_64 = 7'd64;
   localparam logic [CNT_W-1:0] ITER_32 = 7'd32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

   // Sign-extend a 32-bit word result to the full datapath width
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050133_div_unit_step.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050133_div_step
// Description : One combinational restoring-division iteration. Shifts the
//               next dividend bit into the partial remainder and subtracts
//               the divisor when it fits, producing one quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050133_div_step
   import ysyx_22050133_div_unit_pkg::*;
(
   input  logic [XLEN:0]   rem_in,
   input  logic            a_bit,
   input  logic [XLEN-1:0] b,
   output logic [XLEN:0]   rem_out,
   output logic            q_bit
);

   logic [XLEN+1:0] w_shift;
   logic [XLEN+1:0] w_diff;

   // The partial remainder always stays below the divisor, so the top bit of
   // the difference is a clean borrow flag: clear means rem >= b.
   always_comb begin
      w_shift = {rem_in, a_bit};
      w_diff  = w_shift - {2'b00, b};
      q_bit   = ~w_diff[XLEN+1];
      rem_out = q_bit ? w_diff[XLEN:0] : w_shift[XLEN:0];
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050133_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050133_div_unit
// Description : Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/
//               REMU and their *W forms. Accepts on div_valid, returns the
//               registered quotient/remainder with a one-cycle div_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050133_div_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            div_valid,
   input  logic            divw,
   input  logic            div_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            div_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);
   import ysyx_22050133_div_unit_pkg::*;

   localparam logic [XLEN-1:0] c_min_d = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] c_min_w = {{(XLEN-31){1'b1}}, {31{1'b0}}};

   div_state_t       r_state;
   logic [CNT_W-1:0] r_counter;
   logic [XLEN-1:0]  r_a;
   logic [XLEN-1:0]  r_b;
   logic [XLEN:0]    r_rem;
   logic [XLEN-1:0]  r_q;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_divw;

   logic [XLEN-1:0]  w_ext_a, w_ext_b, w_abs_a, w_abs_b;
   logic             w_sa, w_sb, w_div0, w_ovf;
   logic [XLEN:0]    w_rem_next;
   logic             w_q_bit;
   logic [XLEN-1:0]  w_q_fix, w_r_fix;

   // Operand prep: width-extend, take magnitudes and flag the fast-path cases
   always_comb begin
      w_ext_a = dividend;
      w_ext_b = divisor;
      if (divw) begin
         w_ext_a = div_signed ? sext32(dividend[31:0]) : {{(XLEN-32){1'b0}}, dividend[31:0]};
         w_ext_b = div_signed ? sext32(divisor[31:0])  : {{(XLEN-32){1'b0}}, divisor[31:0]};
      end
      w_sa    = div_signed & w_ext_a[XLEN-1];
      w_sb    = div_signed & w_ext_b[XLEN-1];
      w_abs_a = w_sa ? -w_ext_a : w_ext_a;
      w_abs_b = w_sb ? -w_ext_b : w_ext_b;
      w_div0  = (w_ext_b == '0);
      w_ovf   = div_signed && (w_ext_a == (divw ? c_min_w : c_min_d)) && (&w_ext_b);
   end

   ysyx_22050133_div_step u_step (
      .rem_in  (r_rem),
      .a_bit   (r_a[XLEN-1]),
      .b       (r_b),
      .rem_out (w_rem_next),
      .q_bit   (w_q_bit)
   );

   // Result fix-up: restore signs, then sign-extend bit 31 for every *W op
   always_comb begin
      w_q_fix = r_neg_q ? -r_q : r_q;
      w_r_fix = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
      if (r_divw) begin
         w_q_fix = sext32(w_q_fix[31:0]);
         w_r_fix = sext32(w_r_fix[31:0]);
      end
   end

   // Control FSM and datapath registers; div_ready/out_valid pulse from DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_counter <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_rem     <= '0;
         r_q       <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_divw    <= 1'b0;
         div_ready <= 1'b0;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         div_ready <= 1'b0;
         out_valid <= 1'b0;
         if (flush) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (div_valid) begin
                     r_divw    <= divw;
                     r_b       <= w_abs_b;
                     r_counter <= divw ? ITER_32 : ITER_64;
                     if (w_div0) begin
                        // Quotient all-ones, remainder is the (extended) dividend
                        r_q     <= '1;
                        r_rem   <= {1'b0, w_ext_a};
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                        r_state <= ST_DONE;
                     end else if (w_ovf) begin
                        // MIN / -1 wraps back to MIN with zero remainder
                        r_q     <= w_ext_a;
                        r_rem   <= '0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                        r_state <= ST_DONE;
                     end else begin
                        // *W magnitudes fit in 32 bits; park them at the MSB end
                        r_a     <= divw ? {w_abs_a[31:0], {(XLEN-32){1'b0}}} : w_abs_a;
                        r_rem   <= '0;
                        r_q     <= '0;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_state <= ST_BUSY;
                     end
                  end
               end
               ST_BUSY: begin
                  r_rem     <= w_rem_next;
                  r_a       <= {r_a[XLEN-2:0], 1'b0};
                  r_q       <= {r_q[XLEN-2:0], w_q_bit};
                  r_counter <= r_counter - 1'b1;
                  if (r_counter == 7'd1) begin
                     r_state <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  quotient  <= w_q_fix;
                  remainder <= w_r_fix;
                  div_ready <= 1'b1;
                  out_valid <= 1'b1;
                  r_state   <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
